// File: rtl/toggle_meter.sv
// Measures the interval between detected edges of an asynchronous square wave.
// Define TOGGLE_METER_FULL_PERIOD_EN to measure rise-to-rise instead of edge-to-edge.
module toggle_meter #(
  parameter  int unsigned clk_freq_hz = 16_000_000,
  parameter  int unsigned max_cycles  = clk_freq_hz,
  localparam int unsigned cnt_w       = $clog2(max_cycles + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  output logic             level,
  output logic [cnt_w-1:0] period,
  output logic             period_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(max_cycles);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

  state_t           state;
  logic [cnt_w-1:0] cnt;
  logic             s1, s2, s3;
  logic             edge_det;

  // Two-flop synchronizer plus a history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;

`ifdef TOGGLE_METER_FULL_PERIOD_EN
  assign edge_det = s2 & ~s3;
`else
  assign edge_det = s2 ^ s3;
`endif

  // Interval FSM: an edge arriving on the cnt_max cycle still counts as a measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_det) begin
            state   <= MEASURE;
            cnt     <= cnt_one;
            timeout <= 1'b0;
          end else begin
            cnt <= '0;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= cnt_one;
          end else if (cnt == cnt_max) begin
            timeout <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + cnt_one;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_meter.sv
// Self-checking bench for toggle_meter: timestamp-based reference model plus directed literal checks.
module tb_toggle_meter;

  localparam int MAXC = 64;
  localparam int PW   = $clog2(MAXC + 1);

`ifdef TOGGLE_METER_FULL_PERIOD_EN
  localparam int P = 20, BV = 2, CV = 1, DV = 2, EV = 1, G = 32;
`else
  localparam int P = 10, BV = 5, CV = 2, DV = 4, EV = 2, G = 64;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_in  = 1'b0;
  logic          level;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          timeout;

  toggle_meter #(
    .clk_freq_hz(16_000_000),
    .max_cycles (MAXC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_in        (d_in),
    .level       (level),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int vper  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: d_in history taken at each clock, edges timestamped in clock counts
  int m_t, m_last, m_period;
  bit m_meas, m_valid, m_timeout;
  bit h0, h1, h2;

  task automatic model_reset();
    m_t = 0; m_last = 0; m_period = 0;
    m_meas = 0; m_valid = 0; m_timeout = 0;
    h0 = 0; h1 = 0; h2 = 0;
  endtask

  task automatic model_step();
    bit e;
    m_t++;
`ifdef TOGGLE_METER_FULL_PERIOD_EN
    e = h1 & ~h2;
`else
    e = h1 != h2;
`endif
    m_valid = 0;
    if (e) begin
      if (m_meas) begin
        m_period = m_t - m_last;
        m_valid  = 1;
      end else begin
        m_meas    = 1;
        m_timeout = 0;
      end
      m_last = m_t;
    end else if (m_meas && (m_t - m_last == MAXC)) begin
      m_timeout = 1;
      m_meas    = 0;
    end
    h2 = h1;
    h1 = h0;
    h0 = d_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison against the model, plus a strobe monitor for directed checks
  initial begin
    forever begin
      @(negedge clk);
      chk("level",        32'(level),        32'(h1));
      chk("period",       32'(period),       32'(m_period));
      chk("period_valid", 32'(period_valid), 32'(m_valid));
      chk("timeout",      32'(timeout),      32'(m_timeout));
      if (period_valid === 1'b1) begin
        vcnt++;
        vper = int'(period);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int n;

    hold(3);
    rst_n = 1'b1;

    // Idle input after reset
    hold(100);
    #1;
    chk("a_level",   32'(level),        0);
    chk("a_period",  32'(period),       0);
    chk("a_valid",   32'(period_valid), 0);
    chk("a_timeout", 32'(timeout),      0);

    // Steady toggling, then silence
    base = vcnt;
    repeat (6) begin
      d_in = ~d_in;
      hold(10);
    end
    #1;
    chk("b_valids",   32'(vcnt - base), 32'(BV));
    chk("b_period",   32'(vper),        32'(P));
    chk("b_no_tmo",   32'(timeout),     0);
    hold(80);
    #1;
    chk("b_timeout",     32'(timeout), 1);
    chk("b_period_hold", 32'(period),  32'(P));

    // Recovery after timeout: first edge only restarts
    base = vcnt;
    d_in = ~d_in;
    hold(10);
    #1;
    chk("c_tmo_clear", 32'(timeout),     0);
    chk("c_no_valid",  32'(vcnt - base), 0);
    d_in = ~d_in;
    hold(10);
    d_in = ~d_in;
    hold(10);
    #1;
    chk("c_valids", 32'(vcnt - base), 32'(CV));
    chk("c_period", 32'(vper),        32'(P));

    // Edges exactly max_cycles apart: measurement wins over timeout
    base = vcnt;
    d_in = ~d_in;
    repeat (3) begin
      hold(G);
      d_in = ~d_in;
    end
    hold(6);
    #1;
    chk("d_valids",  32'(vcnt - base), 32'(DV));
    chk("d_period",  32'(vper),        32'(MAXC));
    chk("d_timeout", 32'(timeout),     0);

    // Asynchronous reset mid-interval
    d_in = ~d_in;
    hold(10);
    d_in = ~d_in;
    hold(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_level",   32'(level),        0);
    chk("e_period",  32'(period),       0);
    chk("e_valid",   32'(period_valid), 0);
    chk("e_timeout", 32'(timeout),      0);
    d_in = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    hold(5);
    base = vcnt;
    repeat (3) begin
      d_in = ~d_in;
      hold(10);
    end
    #1;
    chk("e_valids",     32'(vcnt - base), 32'(EV));
    chk("e_period_new", 32'(vper),        32'(P));

    // Random intervals, including back-to-back edges and gaps past the timeout
    repeat (300) begin
      n = int'($urandom_range(1, 80));
      if ($urandom_range(0, 3) == 0) n = int'($urandom_range(1, 3));
      hold(n);
      d_in = ~d_in;
    end
    hold(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
